// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// The divide datapath exists only when MDU_DIV_EN is defined; otherwise div/rem ops return 0.
module mdu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              in_sign_a, in_sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_acc, step_lo, fin_res;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0]   mul_res;
`ifdef MDU_DIV_EN
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   div_acc, div_lo, div_res;
  logic              div_ovf;
`endif

  // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM also rs2.
  always_comb begin
    in_sign_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                (funct3 == 3'b110);
    in_sign_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    mag_a = (in_sign_a && op_a[XLEN-1]) ? -op_a : op_a;
    mag_b = (in_sign_b && op_b[XLEN-1]) ? -op_b : op_b;
  end

  // One iteration of the datapath plus the sign fix-up of the finished value.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    prod     = {mul_sum[XLEN:1], mul_sum[0], lo_q[XLEN-1:1]};
    prod_f   = (sign_a_q ^ sign_b_q) ? -prod : prod;
    mul_res  = (funct3_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
    step_acc = prod[2*XLEN-1:XLEN];
    step_lo  = prod[XLEN-1:0];
    fin_res  = mul_res;
`ifdef MDU_DIV_EN
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (!div_diff[XLEN]) begin
      div_acc = div_diff[XLEN-1:0];
      div_lo  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_acc = div_shift[XLEN-1:0];
      div_lo  = {lo_q[XLEN-2:0], 1'b0};
    end
    if (funct3_q[1]) begin
      div_res = sign_a_q ? -div_acc : div_acc;
    end else begin
      div_res = (sign_a_q ^ sign_b_q) ? -div_lo : div_lo;
    end
    if (funct3_q[2]) begin
      step_acc = div_acc;
      step_lo  = div_lo;
      fin_res  = div_res;
    end
    div_ovf = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1) && !funct3[0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    funct3_d = funct3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    done_d   = 1'b0;
    result_d = result_q;
    stall    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          stall    = 1'b1;
          funct3_d = funct3;
          sign_a_d = in_sign_a && op_a[XLEN-1];
          sign_b_d = in_sign_b && op_b[XLEN-1];
          count_d  = CntW'(XLEN);
          acc_d    = '0;
          lo_d     = mag_a;
          opb_d    = mag_b;
          state_d  = StCalc;
          if (funct3[2]) begin
`ifdef MDU_DIV_EN
            if (op_b == '0) begin
              state_d  = StFin;
              done_d   = 1'b1;
              result_d = funct3[1] ? op_a : '1;
            end else if (div_ovf) begin
              state_d  = StFin;
              done_d   = 1'b1;
              result_d = funct3[1] ? '0 : op_a;
            end
`else
            state_d  = StFin;
            done_d   = 1'b1;
            result_d = '0;
`endif
          end
        end
      end
      StCalc: begin
        stall = 1'b1;
        if (flush) begin
          state_d = StIdle;
        end else begin
          acc_d   = step_acc;
          lo_d    = step_lo;
          count_d = count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_d  = StFin;
            done_d   = 1'b1;
            result_d = fin_res;
          end
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      funct3_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      funct3_q <= funct3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
